// File: rtl/mem_loader_if.sv
// Byte-stream in / RAM-write out bundle for mem_loader.
// The loader is the master of the RAM write port and of the byte_ready side of the stream.
`timescale 1ns/1ps

interface mem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [ADDRESS_WIDTH-1:0] word_count;
  logic                     abort;

  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;

  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  logic                     busy;
  logic                     done;
  logic                     aborted;

  modport master (
    input  start, base_addr, word_count, abort,
    input  byte_in, byte_valid,
    output byte_ready,
    output wr_en, wr_addr, wr_data,
    output busy, done, aborted
  );

  modport slave (
    output start, base_addr, word_count, abort,
    output byte_in, byte_valid,
    input  byte_ready,
    input  wr_en, wr_addr, wr_data,
    input  busy, done, aborted
  );
endinterface

// File: rtl/mem_loader.sv
// Packs a big-endian byte stream into DATA_WIDTH-bit words and writes them to
// consecutive RAM addresses (wrapping modulo DEPTH). DATA_WIDTH must be a multiple of 8.
`timescale 1ns/1ps

module mem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 512
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_loader_if.master bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDRESS_WIDTH + 1;

  localparam logic [CNT_W-1:0]         DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BC_W-1:0]          LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] TOP_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [BC_W-1:0]          byte_cnt_q;
  logic [CNT_W-1:0]         idx_q;
  logic [CNT_W-1:0]         count_q;
  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0]    shift_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic                     aborted_q;

  logic                     start_ok;
  logic [CNT_W-1:0]         start_count;
  logic                     accept;
  logic                     last_byte;
  logic                     last_word;
  logic                     active;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [ADDRESS_WIDTH-1:0] req);
    logic [CNT_W-1:0] ext;
    ext = {1'b0, req};
    return (ext > DEPTH_C) ? DEPTH_C : ext;
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] wrap_addr(input logic [ADDRESS_WIDTH-1:0] a);
    return ADDRESS_WIDTH'({1'b0, a} % DEPTH_C);
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a);
    return (a == TOP_ADDR) ? '0 : a + ADDRESS_WIDTH'(1);
  endfunction

  // Older bytes move toward the MSB; whatever was above them falls off the top.
  function automatic logic [DATA_WIDTH-1:0] pack_word(input logic [DATA_WIDTH-1:0] acc,
                                                      input logic [7:0]            b);
    return DATA_WIDTH'({acc, b});
  endfunction

  assign active      = (state == ASSEMBLE) || (state == WRITE);
  assign start_ok    = (state == IDLE) && bus.start;
  assign start_count = clamp_count(bus.word_count);
  // abort wins over a simultaneous byte handshake
  assign accept      = (state == ASSEMBLE) && bus.byte_valid && !bus.abort;
  assign last_byte   = accept && (byte_cnt_q == LAST_BYTE);
  assign last_word   = ((idx_q + CNT_W'(1)) == count_q);

  // ---- stage: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- stage: next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (start_count == '0) ? DONE : ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (last_word) begin
          state_next = DONE;
        end else begin
          state_next = ASSEMBLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- stage: state-decoded outputs
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.wr_en      = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      ASSEMBLE: begin
        bus.byte_ready = 1'b1;
        bus.busy       = 1'b1;
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        bus.busy  = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.aborted = aborted_q;

  // ---- stage: load bookkeeping and RAM write registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      aborted_q  <= 1'b0;
    end else begin
      aborted_q <= bus.abort && active;

      if (start_ok) begin
        count_q    <= start_count;
        ptr_q      <= wrap_addr(bus.base_addr);
        idx_q      <= '0;
        byte_cnt_q <= '0;
      end

      if (accept) begin
        if (last_byte) begin
          byte_cnt_q <= '0;
          wr_addr_q  <= ptr_q;
          wr_data_q  <= pack_word(shift_q, bus.byte_in);
        end else begin
          byte_cnt_q <= byte_cnt_q + BC_W'(1);
        end
      end

      if (state == WRITE) begin
        idx_q <= idx_q + CNT_W'(1);
        ptr_q <= next_addr(ptr_q);
      end
    end
  end

  // Partial-word shifter; byte_cnt_q alone decides which bytes form a word.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= pack_word(shift_q, bus.byte_in);
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed-vector bench for mem_loader: packing, handshake gaps, address wrap,
// zero-length loads, abort, reset mid-word, start-while-busy and count clamping.
`timescale 1ns/1ps

module tb_mem_loader;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int DEP = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

  mem_loader #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int n_done   = 0;
  int n_abort  = 0;
  int rdy_viol = 0;

  // Write/pulse monitor, sampled at the active edge on pre-edge values.
  always @(posedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      if (bus.byte_ready) rdy_viol++;
    end
    if (bus.done)    n_done++;
    if (bus.aborted) n_abort++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    n_done  = 0;
    n_abort = 0;
  endtask

  // All tasks start and end just after a negedge.
  task automatic start_load(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 64'(bus.byte_ready), 64'd1);
    else @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int t = 0;
    while (!bus.done && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(bus.done), 64'd1);
    @(negedge clk);
  endtask

  task automatic expect_wr(input string tag, input int idx, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, 64'(wa_q[idx]), 64'(a));
      check({tag, "_data"}, 64'(wd_q[idx]), 64'(d));
    end else begin
      check({tag, "_missing"}, 64'(wa_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
    check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
    check({tag, "_wr_data"},    64'(bus.wr_data),    64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_done"},       64'(bus.done),       64'd0);
    check({tag, "_aborted"},    64'(bus.aborted),    64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t2_words [3];
    t2_words[0] = 32'h10111213;
    t2_words[1] = 32'h14151617;
    t2_words[2] = 32'h18191A1B;

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.abort      = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single word, back-to-back bytes, exact write/done timing
    clear_log();
    start_load(12'd0, 12'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    check("t1_wr_en",   64'(bus.wr_en),      64'd1);
    check("t1_addr",    64'(bus.wr_addr),    64'd0);
    check("t1_data",    64'(bus.wr_data),    64'hDEADBEEF);
    check("t1_ready",   64'(bus.byte_ready), 64'd0);
    check("t1_busy",    64'(bus.busy),       64'd1);
    @(negedge clk);
    check("t1_done",    64'(bus.done),       64'd1);
    check("t1_wr_off",  64'(bus.wr_en),      64'd0);
    check("t1_busy_dn", 64'(bus.busy),       64'd0);
    check("t1_hold",    64'(bus.wr_data),    64'hDEADBEEF);
    @(negedge clk);
    check("t1_done_1c", 64'(bus.done),       64'd0);
    check("t1_nwr",     64'(wa_q.size()),    64'd1);

    // 2: three words with byte_valid toggling
    clear_log();
    start_load(12'd10, 12'd3);
    for (int w = 0; w < 3; w++) send_word(t2_words[w], 1);
    wait_done("t2_done", 20);
    check("t2_nwr", 64'(wa_q.size()), 64'd3);
    for (int w = 0; w < 3; w++) expect_wr($sformatf("t2_w%0d", w), w, AW'(10 + w), t2_words[w]);

    // 3: address wrap at DEPTH
    clear_log();
    start_load(12'd510, 12'd4);
    for (int k = 0; k < 16; k++) send_byte(8'hA0 + 8'(k), 0);
    wait_done("t3_done", 20);
    check("t3_nwr", 64'(wa_q.size()), 64'd4);
    expect_wr("t3_w0", 0, 12'd510, 32'hA0A1A2A3);
    expect_wr("t3_w1", 1, 12'd511, 32'hA4A5A6A7);
    expect_wr("t3_w2", 2, 12'd0,   32'hA8A9AAAB);
    expect_wr("t3_w3", 3, 12'd1,   32'hACADAEAF);

    // 4: zero-length load
    clear_log();
    start_load(12'd7, 12'd0);
    check("t4_done",   64'(bus.done),       64'd1);
    check("t4_busy",   64'(bus.busy),       64'd0);
    check("t4_ready",  64'(bus.byte_ready), 64'd0);
    @(negedge clk);
    check("t4_done_1c", 64'(bus.done),      64'd0);
    check("t4_nwr",     64'(wa_q.size()),   64'd0);
    check("t4_ndone",   64'(n_done),        64'd1);

    // 5: abort two bytes into word 2 (with a byte offered on the same cycle)
    clear_log();
    start_load(12'd20, 12'd2);
    send_word(32'h55667788, 0);
    send_byte(8'h99, 0);
    send_byte(8'hAA, 0);
    bus.abort      = 1'b1;
    bus.byte_in    = 8'hBB;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    check("t5_aborted", 64'(bus.aborted), 64'd1);
    check("t5_busy",    64'(bus.busy),    64'd0);
    check("t5_ready",   64'(bus.byte_ready), 64'd0);
    @(negedge clk);
    check("t5_aborted_1c", 64'(bus.aborted), 64'd0);
    check("t5_nabort", 64'(n_abort), 64'd1);
    check("t5_ndone",  64'(n_done),  64'd0);
    check("t5_nwr",    64'(wa_q.size()), 64'd1);
    expect_wr("t5_w0", 0, 12'd20, 32'h55667788);
    clear_log();
    start_load(12'd30, 12'd1);
    send_word(32'h11223344, 0);
    wait_done("t5b_done", 10);
    check("t5b_nwr", 64'(wa_q.size()), 64'd1);
    expect_wr("t5b_w0", 0, 12'd30, 32'h11223344);

    // 6: reset mid-word, then a clean load with a stray start while busy
    clear_log();
    start_load(12'd40, 12'd1);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst1");
    reset_n = 1'b1;
    @(negedge clk);
    clear_log();
    start_load(12'd5, 12'd1);
    send_byte(8'h01, 0);
    start_load(12'd100, 12'd7);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    wait_done("t6_done", 10);
    check("t6_idle_busy", 64'(bus.busy), 64'd0);
    check("t6_nwr", 64'(wa_q.size()), 64'd1);
    expect_wr("t6_w0", 0, 12'd5, 32'h01020304);

    // 7: word_count above DEPTH clamps to DEPTH
    clear_log();
    start_load(12'd0, 12'd600);
    for (int k = 0; k < 4 * DEP; k++) send_byte(k[7:0], 0);
    wait_done("t7_done", 10);
    check("t7_nwr", 64'(wa_q.size()), 64'(DEP));
    expect_wr("t7_first", 0, 12'd0, 32'h00010203);
    expect_wr("t7_last", DEP - 1, 12'd511, 32'hFCFDFEFF);

    check("ready_in_write", 64'(rdy_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
